lsu_ram_port: RTL and testbench

//  Load/store responder for the control decoder's RAM_* signals; sits between the core datapath and the word-wide data RAM.

---
 rtl/lsu_ram_port.sv | 227 ++++++++++++++++++++++
 tb/tb_lsu_ram_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ram_port.sv
// Load/store port between the core datapath and a word-wide data RAM.
// Handles byte lanes, split misaligned accesses, extension and stall.
module lsu_ram_port #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_read_en,
  input  logic              ram_write_en,
  input  logic [3:0]        ram_type,
  input  logic              ram_sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [31:0]       load_data,
  output logic              lsu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] T_BYTE = 4'd1;
  localparam logic [3:0] T_HALF = 4'd2;
  localparam logic [3:0] T_WORD = 4'd4;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic              we_q, we_d;
  logic              phase_q, phase_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [63:0]       rbuf_q, rbuf_d;

  logic [1:0]  off;
  logic [2:0]  end_w;
  logic        split;
  logic        tmo;
  logic [7:0]  mask_n;
  logic [7:0]  m8;
  logic [31:0] wm;
  logic [63:0] w64;
  logic [31:0] raw;
  logic [31:0] ext;

  assign off   = addr_q[1:0];
  assign end_w = {1'b0, off} + size_q;
  assign split = end_w > 3'd4;
  assign tmo   = cnt_q == CW'(TIMEOUT - 1);

  always_comb begin
    mask_n = 8'h0F;
    unique case (size_q)
      3'd1:    mask_n = 8'h01;
      3'd2:    mask_n = 8'h03;
      default: mask_n = 8'h0F;
    endcase
  end

  // 8-lane view spans both words of a split access
  assign m8  = mask_n << off;
  assign wm  = wdata_q & {{8{mask_n[3]}}, {8{mask_n[2]}},
                          {8{mask_n[1]}}, {8{mask_n[0]}}};
  assign w64 = {32'b0, wm} << {off, 3'b000};
  assign raw = 32'(rbuf_q >> {off, 3'b000});

  always_comb begin
    ext = raw;
    unique case (size_q)
      3'd1:    ext = {{24{sign_q & raw[7]}}, raw[7:0]};
      3'd2:    ext = {{16{sign_q & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      phase_q <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
      rbuf_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      we_q    <= we_d;
      phase_q <= phase_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sign_d  = sign_q;
    we_d    = we_q;
    phase_d = phase_q;
    err_d   = err_q;
    abort_d = abort_q;
    rbuf_d  = rbuf_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (ram_read_en | ram_write_en) begin
          addr_d  = addr;
          wdata_d = wdata;
          sign_d  = ram_sign;
          we_d    = ram_write_en;
          phase_d = 1'b0;
          err_d   = ram_read_en & ram_write_en;
          abort_d = 1'b0;
          rbuf_d  = '0;
          state_d = S_REQ;
          unique case (1'b1)
            (ram_type == T_BYTE): size_d = 3'd1;
            (ram_type == T_HALF): size_d = 3'd2;
            (ram_type == T_WORD): size_d = 3'd4;
            default: begin
              size_d  = 3'd4;
              err_d   = 1'b1;
              abort_d = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          if (!we_q) state_d = S_WAIT;
          else if (split && !phase_q) phase_d = 1'b1;
          else state_d = S_DONE;
        end else if (tmo) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (phase_q) rbuf_d[63:32] = mem_rdata;
          else rbuf_d[31:0] = mem_rdata;
          if (split && !phase_q) begin
            phase_d = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end else if (tmo) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lsu_stall = 1'b0;
    lsu_done  = 1'b0;
    load_data = '0;
    lsu_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: lsu_stall = ram_read_en | ram_write_en;
      S_REQ: begin
        lsu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q[ADDR_W-1:2]
                  + (ADDR_W-2)'(phase_q);
        mem_be    = phase_q ? m8[7:4] : m8[3:0];
        mem_wdata = phase_q ? w64[63:32] : w64[31:0];
      end
      S_WAIT: lsu_stall = 1'b1;
      default: begin
        lsu_done = 1'b1;
        lsu_err  = err_q;
        if (!we_q && !abort_q) load_data = ext;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_ram_port.sv
// Directed bench for lsu_ram_port with a one-cycle-read RAM model.
// Accepted requests are logged and compared against hand-derived values.
module tb_lsu_ram_port;

  localparam logic [3:0] T_B = 4'd1;
  localparam logic [3:0] T_H = 4'd2;
  localparam logic [3:0] T_W = 4'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_read_en = 1'b0;
  logic        ram_write_en = 1'b0;
  logic [3:0]  ram_type = 4'd0;
  logic        ram_sign = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        lsu_stall, lsu_done, lsu_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        ready_en = 1'b1;
  logic        rv_en = 1'b1;
  logic [29:0] rw_addr0 = '0;
  logic [31:0] rw0 = '0;
  logic [31:0] rw1 = '0;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;

  logic [29:0] acc_addr [16];
  logic [3:0]  acc_be   [16];
  logic        acc_we   [16];
  logic [31:0] acc_wd   [16];
  int          acc_n = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_ready  = ready_en;
  assign mem_rvalid = rv_q & rv_en;
  assign mem_rdata  = rd_q;

  always @(posedge clk) begin
    rv_q <= mem_req & ~mem_we & mem_ready;
    rd_q <= (mem_addr == rw_addr0) ? rw0 : rw1;
    if (mem_req && mem_ready) begin
      acc_addr[acc_n % 16] <= mem_addr;
      acc_be[acc_n % 16]   <= mem_be;
      acc_we[acc_n % 16]   <= mem_we;
      acc_wd[acc_n % 16]   <= mem_wdata;
      acc_n <= acc_n + 1;
    end
  end

  lsu_ram_port dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .ram_type     (ram_type),
    .ram_sign     (ram_sign),
    .addr         (addr),
    .wdata        (wdata),
    .lsu_stall    (lsu_stall),
    .lsu_done     (lsu_done),
    .load_data    (load_data),
    .lsu_err      (lsu_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input logic [3:0] ty, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    ram_read_en  = rd;
    ram_write_en = wr;
    ram_type     = ty;
    ram_sign     = sg;
    addr         = a;
    wdata        = wd;
  endtask

  // lat counts cycles from the IDLE accept cycle to the done cycle
  task automatic do_op(input logic rd, input logic wr,
                       input logic [3:0] ty, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] ld,
                       output logic er, output logic stall_ok,
                       output int start, output int reqs);
    @(posedge clk);
    #1;
    start = acc_n;
    drive(rd, wr, ty, sg, a, wd);
    #1;
    stall_ok = lsu_stall;
    lat = 0;
    reqs = 0;
    ld = '0;
    er = 1'b0;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      #2;
      if (lat == 1) drive(1'b0, 1'b0, 4'd0, 1'b0, '0, '0);
      if (lsu_done) break;
      if (!lsu_stall) stall_ok = 1'b0;
      if (mem_req) reqs++;
    end
    ld = load_data;
    er = lsu_err;
  endtask

  int          lat, st, rq;
  logic [31:0] ld;
  logic        er, sok;

  initial begin
    #3;
    check("rst_stall", 32'(lsu_stall), 0);
    check("rst_done", 32'(lsu_done), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_err", 32'(lsu_err), 0);
    check("rst_ld", load_data, 0);
    #20 rst_n = 1'b1;

    rw_addr0 = 30'h40; rw0 = 32'hDEADBEEF;
    do_op(1, 0, T_W, 0, 32'h100, 0, lat, ld, er, sok, st, rq);
    check("lw_lat", lat, 3);
    check("lw_data", ld, 32'hDEADBEEF);
    check("lw_err", 32'(er), 0);
    check("lw_stall", 32'(sok), 1);
    check("lw_addr", 32'(acc_addr[st % 16]), 32'h40);
    check("lw_be", 32'(acc_be[st % 16]), 4'hF);

    rw_addr0 = 30'h80; rw0 = 32'h80123456;
    do_op(1, 0, T_B, 1, 32'h203, 0, lat, ld, er, sok, st, rq);
    check("lb_be", 32'(acc_be[st % 16]), 4'h8);
    check("lb_data", ld, 32'hFFFFFF80);
    do_op(1, 0, T_B, 0, 32'h203, 0, lat, ld, er, sok, st, rq);
    check("lbu_data", ld, 32'h00000080);

    do_op(0, 1, T_H, 0, 32'h7, 32'h0000ABCD, lat, ld, er, sok, st, rq);
    check("sh_lat", lat, 3);
    check("sh_n", acc_n - st, 2);
    check("sh_a0", 32'(acc_addr[st % 16]), 1);
    check("sh_be0", 32'(acc_be[st % 16]), 4'h8);
    check("sh_wd0", acc_wd[st % 16], 32'hCD000000);
    check("sh_a1", 32'(acc_addr[(st + 1) % 16]), 2);
    check("sh_be1", 32'(acc_be[(st + 1) % 16]), 4'h1);
    check("sh_wd1", acc_wd[(st + 1) % 16], 32'h000000AB);
    check("sh_we", 32'(acc_we[st % 16]), 1);
    @(posedge clk);
    #2;
    check("sh_pulse", 32'(lsu_done), 0);

    rw_addr0 = 30'h3FFFFFFF; rw0 = 32'h11223344; rw1 = 32'h55667788;
    do_op(1, 0, T_W, 0, 32'hFFFFFFFE, 0, lat, ld, er, sok, st, rq);
    check("lwx_lat", lat, 5);
    check("lwx_data", ld, 32'h77881122);
    check("lwx_a1", 32'(acc_addr[(st + 1) % 16]), 0);
    check("lwx_be0", 32'(acc_be[st % 16]), 4'hC);
    check("lwx_be1", 32'(acc_be[(st + 1) % 16]), 4'h3);
    check("lwx_stall", 32'(sok), 1);

    do_op(0, 1, T_W, 0, 32'h10, 32'hCAFEF00D, lat, ld, er, sok, st, rq);
    check("sw_lat", lat, 2);
    check("sw_wd", acc_wd[st % 16], 32'hCAFEF00D);
    check("sw_a", 32'(acc_addr[st % 16]), 4);
    check("sw_ld", ld, 0);

    do_op(0, 1, T_B, 0, 32'h21, 32'hFFFFFF5A, lat, ld, er, sok, st, rq);
    check("sb_be", 32'(acc_be[st % 16]), 4'h2);
    check("sb_wd", acc_wd[st % 16], 32'h00005A00);

    rw_addr0 = 30'h0; rw0 = 32'h80017777;
    do_op(1, 0, T_H, 1, 32'h2, 0, lat, ld, er, sok, st, rq);
    check("lh_be", 32'(acc_be[st % 16]), 4'hC);
    check("lh_data", ld, 32'hFFFF8001);

    do_op(1, 0, 4'b0000, 0, 32'h100, 0, lat, ld, er, sok, st, rq);
    check("inv_lat", lat, 1);
    check("inv_err", 32'(er), 1);
    check("inv_ld", ld, 0);
    check("inv_nacc", acc_n - st, 0);

    do_op(1, 1, T_W, 0, 32'h30, 32'h1, lat, ld, er, sok, st, rq);
    check("both_lat", lat, 2);
    check("both_err", 32'(er), 1);
    check("both_we", 32'(acc_we[st % 16]), 1);

    ready_en = 1'b0;
    do_op(1, 0, T_W, 0, 32'h100, 0, lat, ld, er, sok, st, rq);
    check("tmo_lat", lat, 256);
    check("tmo_reqs", rq, 255);
    check("tmo_err", 32'(er), 1);
    check("tmo_ld", ld, 0);
    check("tmo_req", 32'(mem_req), 0);

    @(posedge clk);
    #1 drive(1, 0, T_W, 0, 32'h100, 0);
    @(posedge clk);
    #1 drive(0, 0, 4'd0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("rq_req", 32'(mem_req), 1);
    check("rq_addr", 32'(mem_addr), 32'h40);
    rst_n = 1'b0;
    #1;
    check("rq_rst_req", 32'(mem_req), 0);
    check("rq_rst_stall", 32'(lsu_stall), 0);
    #5 rst_n = 1'b1;

    ready_en = 1'b1;
    rv_en = 1'b0;
    @(posedge clk);
    #1 drive(1, 0, T_W, 0, 32'h100, 0);
    @(posedge clk);
    #1 drive(0, 0, 4'd0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("wt_stall", 32'(lsu_stall), 1);
    rst_n = 1'b0;
    #1;
    check("wt_rst_stall", 32'(lsu_stall), 0);
    check("wt_rst_done", 32'(lsu_done), 0);
    #5 rst_n = 1'b1;
    rv_en = 1'b1;

    rw_addr0 = 30'h40; rw0 = 32'h0BADF00D;
    do_op(1, 0, T_W, 0, 32'h100, 0, lat, ld, er, sok, st, rq);
    check("post_lat", lat, 3);
    check("post_data", ld, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
